inst_buffer: RTL and testbench

- Instruction fetch queue between ifetch and decode/dispatch.
- Absorbs IF_ID_PACKETs from ifetch and presents them in order, one per cycle, to decode.
- Back-pressures fetch through if_valid and discards all queued instructions on a redirect (branch resolve or ROB target).

---
 rtl/inst_buffer.sv | 63 ++++++
 tb/tb_inst_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - in-order instruction fetch queue between ifetch and decode
// Packet layout: [96] valid, [95:64] inst, [63:32] PC, [31:0] NPC.
module inst_buffer #(
   parameter int DEPTH              = 8,
   parameter int ALMOST_FULL_THRESH = 6
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [96:0]              if_packet_in,
   output logic                     if_valid,
   input  logic                     flush,
   output logic [96:0]              out_packet,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     almost_full,
   output logic                     empty
);
   localparam int            PW      = $clog2(DEPTH);
   localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
   localparam logic [PW:0]   AF_C    = (PW+1)'(ALMOST_FULL_THRESH);
   localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [95:0]   mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic          push;
   logic          pop;

   // if_valid looks only at registered count, so a pop never frees a slot in the same cycle
   assign if_valid    = (count < DEPTH_C) && !reset;
   assign out_packet  = {count != '0, mem[head]};
   assign push        = if_packet_in[96] && if_valid && !flush;
   assign pop         = out_packet[96] && out_ready && !flush;
   assign almost_full = count >= AF_C;
   assign empty       = count == '0;

   always_ff @(posedge clock) begin
      if (push) begin
         mem[tail] <= if_packet_in[95:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + PTR_ONE;
         end
         if (pop) begin
            head <= head + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_inst_buffer.sv
// tb/tb_inst_buffer.sv - self-checking bench for inst_buffer against a queue model
module tb_inst_buffer;
   localparam int DEPTH = 8;
   localparam int AF    = 6;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [96:0] if_packet_in = '0;
   logic        if_valid;
   logic        flush = 1'b0;
   logic [96:0] out_packet;
   logic        out_ready = 1'b0;
   logic [3:0]  count;
   logic        almost_full;
   logic        empty;

   int n_tests = 0;
   int n_fail  = 0;
   logic [95:0] q[$];

   inst_buffer #(.DEPTH(DEPTH), .ALMOST_FULL_THRESH(AF)) dut (
      .clock(clock), .reset(reset), .if_packet_in(if_packet_in), .if_valid(if_valid),
      .flush(flush), .out_packet(out_packet), .out_ready(out_ready), .count(count),
      .almost_full(almost_full), .empty(empty)
   );

   always #5 clock = ~clock;

   // Drive one cycle of inputs, advance the queue model across the edge, return at negedge.
   task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl, input logic rst);
      bit push_ok;
      bit pop_ok;
      if_packet_in = {v, inst, pc, pc + 32'd4};
      out_ready    = rdy;
      flush        = fl;
      reset        = rst;
      @(posedge clock);
      if (rst || fl) begin
         q.delete();
      end else begin
         push_ok = v && (q.size() < DEPTH);
         pop_ok  = rdy && (q.size() > 0);
         if (pop_ok) void'(q.pop_front());
         if (push_ok) q.push_back(if_packet_in[95:0]);
      end
      @(negedge clock);
   endtask

   task automatic test_reset;
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      n_tests++;
      if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid_held: got %b want 0", if_valid); end
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      n_tests++;
      if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
      n_tests++;
      if (if_valid !== 1'b1) begin n_fail++; $display("FAIL reset_if_valid: got %b want 1", if_valid); end
      n_tests++;
      if (out_packet[96] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_packet[96]); end
      n_tests++;
      if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %b want 0", almost_full); end
   endtask

   task automatic test_fill_stall;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 32'(i * 4), 32'(i * 4 + 'h100), 1'b0, 1'b0, 1'b0);
         n_tests++;
         if (count !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
         n_tests++;
         if (almost_full !== (i + 1 >= AF)) begin n_fail++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, almost_full, (i + 1 >= AF)); end
         n_tests++;
         if (if_valid !== (i + 1 < DEPTH)) begin n_fail++; $display("FAIL fill_if_valid[%0d]: got %b want %b", i, if_valid, (i + 1 < DEPTH)); end
      end
      step(1'b1, 32'h20, 32'h120, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (count !== 4'd8) begin n_fail++; $display("FAIL fill_ninth_dropped: got count %0d want 8", count); end
      n_tests++;
      if (out_packet[63:32] !== 32'h0) begin n_fail++; $display("FAIL fill_head_pc: got %h want 0", out_packet[63:32]); end
   endtask

   task automatic test_drain;
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (out_packet[96] !== 1'b1 || out_packet[63:32] !== 32'(i * 4) || out_packet[95:64] !== 32'(i * 4 + 'h100)
             || out_packet[31:0] !== 32'(i * 4 + 4)) begin
            n_fail++;
            $display("FAIL drain_head[%0d]: got v=%b pc=%h inst=%h npc=%h want v=1 pc=%h", i, out_packet[96],
                     out_packet[63:32], out_packet[95:64], out_packet[31:0], i * 4);
         end
         step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      end
      n_tests++;
      if (empty !== 1'b1 || out_packet[96] !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got empty=%b v=%b want 1/0", empty, out_packet[96]); end
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (count !== 4'd0 || out_packet[96] !== 1'b0) begin n_fail++; $display("FAIL drain_pop_on_empty: got count=%0d v=%b want 0/0", count, out_packet[96]); end
   endtask

   task automatic test_full_pop;
      for (int i = 0; i < 8; i++) step(1'b1, 32'(i * 4 + 'h300), 32'(i), 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (if_valid !== 1'b0) begin n_fail++; $display("FAIL full_pop_if_valid: got %b want 0", if_valid); end
      step(1'b1, 32'h40, 32'h140, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (count !== 4'd7) begin n_fail++; $display("FAIL full_pop_count: got %0d want 7", count); end
      n_tests++;
      if (if_valid !== 1'b1) begin n_fail++; $display("FAIL full_pop_if_valid_next: got %b want 1", if_valid); end
      for (int i = 1; i < 8; i++) begin
         n_tests++;
         if (out_packet[63:32] !== 32'(i * 4 + 'h300) || out_packet[63:32] === 32'h40) begin
            n_fail++; $display("FAIL full_pop_order[%0d]: got pc=%h want %h", i, out_packet[63:32], i * 4 + 'h300);
         end
         step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      end
      n_tests++;
      if (empty !== 1'b1) begin n_fail++; $display("FAIL full_pop_0x40_absent: got empty=%b count=%0d want empty", empty, count); end
   endtask

   task automatic test_stream_wrap;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 32'(i * 4), 32'(i + 'h500), 1'b1, 1'b0, 1'b0);
         n_tests++;
         if (out_packet[96] !== 1'b1 || out_packet[63:32] !== 32'(i * 4) || count !== 4'd1) begin
            n_fail++; $display("FAIL stream[%0d]: got v=%b pc=%h count=%0d want v=1 pc=%h count=1", i,
                               out_packet[96], out_packet[63:32], count, i * 4);
         end
      end
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (empty !== 1'b1) begin n_fail++; $display("FAIL stream_final_empty: got %b want 1", empty); end
   endtask

   task automatic test_flush;
      for (int i = 0; i < 5; i++) step(1'b1, 32'(i * 4 + 'h600), 32'(i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h80, 32'h180, 1'b1, 1'b1, 1'b0);
      n_tests++;
      if (count !== 4'd0 || out_packet[96] !== 1'b0 || if_valid !== 1'b1) begin
         n_fail++; $display("FAIL flush_state: got count=%0d v=%b if_valid=%b want 0/0/1", count, out_packet[96], if_valid);
      end
      step(1'b1, 32'h200, 32'h300, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (out_packet[96] !== 1'b1 || out_packet[63:32] !== 32'h200 || count !== 4'd1) begin
         n_fail++; $display("FAIL flush_next_head: got v=%b pc=%h count=%0d want 1/200/1", out_packet[96], out_packet[63:32], count);
      end
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 3; i++) step(1'b1, 32'(i * 4 + 'h700), 32'(i), 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (count !== 4'd0 || empty !== 1'b1 || if_valid !== 1'b1 || out_packet[96] !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_state: got count=%0d empty=%b if_valid=%b v=%b want 0/1/1/0",
                            count, empty, if_valid, out_packet[96]);
      end
      step(1'b1, 32'h0, 32'h77, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (out_packet[96] !== 1'b1 || out_packet[63:32] !== 32'h0 || out_packet[95:64] !== 32'h77) begin
         n_fail++; $display("FAIL reset_mid_first: got v=%b pc=%h inst=%h want 1/0/77", out_packet[96], out_packet[63:32], out_packet[95:64]);
      end
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_random;
      int bad;
      for (int c = 0; c < 600; c++) begin
         step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 1) == 1,
              $urandom_range(0, 31) == 0, $urandom_range(0, 79) == 0);
         bad = 0;
         if (count !== 4'(q.size())) bad = 1;
         if (empty !== (q.size() == 0)) bad = 1;
         if (almost_full !== (q.size() >= AF)) bad = 1;
         if (if_valid !== ((q.size() < DEPTH) && !reset)) bad = 1;
         if (out_packet[96] !== (q.size() != 0)) bad = 1;
         if (q.size() != 0 && out_packet[95:0] !== q[0]) bad = 1;
         n_tests++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL random[%0d]: got count=%0d v=%b if_valid=%b af=%b head=%h want count=%0d head=%h",
                     c, count, out_packet[96], if_valid, almost_full, out_packet[95:0], q.size(),
                     (q.size() != 0) ? q[0] : 96'h0);
         end
      end
   endtask

   initial begin
      @(negedge clock);
      test_reset();
      test_fill_stall();
      test_drain();
      test_full_pop();
      test_stream_wrap();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
